// File: rtl/fifo_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_serializer
//  Purpose  : Pulls words from an async_fifo read port and emits each one as
//             a framed serial packet: sync pattern, data MSB-first, optional
//             even-parity bit, then an idle-high gap.
//  Options  : define SER_PARITY_EN to insert the even-parity bit after data.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_serializer #(
    parameter int          LOGIC_SIZE   = 32,
    parameter int          SYNC_BITS    = 8,
    parameter logic [15:0] SYNC_PATTERN = 16'h00D5,
    parameter int          GAP_BITS     = 2,
    parameter int          BIT_DIV      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_rempty,
    output logic                  o_rr,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    output logic                  o_tx,
    output logic                  o_tx_active,
    output logic                  o_busy,
    output logic [15:0]           o_word_cnt
);

    localparam int c_BCW = $clog2(LOGIC_SIZE + 1);
    localparam int c_DW  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [c_BCW-1:0] c_SYNC_LAST = c_BCW'(SYNC_BITS - 1);
    localparam logic [c_BCW-1:0] c_DATA_LAST = c_BCW'(LOGIC_SIZE - 1);
    localparam logic [c_BCW-1:0] c_GAP_LAST  = c_BCW'(GAP_BITS - 1);
    localparam logic [c_DW-1:0]  c_DIV_LAST  = c_DW'(BIT_DIV - 1);

    // Sync pattern left-justified so its first bit always sits at [15]
    localparam logic [15:0] c_SYNC_ALIGNED = SYNC_PATTERN << (16 - SYNC_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SYNC   = 3'd3,
        S_DATA   = 3'd4,
        S_GAP    = 3'd5
`ifdef SER_PARITY_EN
        , S_PARITY = 3'd6
`endif
    } state_t;

    state_t                  state_q;
    logic                    rr_q;
    logic                    tx_q;
    logic                    active_q;
    logic                    busy_q;
    logic [15:0]             word_cnt_q;
    logic [LOGIC_SIZE-1:0]   shift_q;
    logic [15:0]             sync_q;
    logic [c_BCW-1:0]        bit_q;
    logic [c_DW-1:0]         div_q;
`ifdef SER_PARITY_EN
    logic                    parity_q;
`endif

    logic [15:0]             word_cnt_d;
    logic [c_BCW-1:0]        bit_d;
    logic [c_DW-1:0]         div_d;
    logic                    div_last;

    assign word_cnt_d = word_cnt_q + 16'd1;
    assign bit_d      = bit_q + c_BCW'(1);
    assign div_d      = div_q + c_DW'(1);
    assign div_last   = (div_q == c_DIV_LAST);

    // Frame sequencer: every output is a register updated here
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            sync_q     <= '0;
            bit_q      <= '0;
            div_q      <= '0;
`ifdef SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            rr_q <= 1'b0;
            // Divider free-runs in every bit-emitting state; wraps after BIT_DIV clocks
            div_q <= div_last ? '0 : div_d;

            case (state_q)
                S_IDLE: begin
                    tx_q     <= 1'b1;
                    active_q <= 1'b0;
                    div_q    <= '0;
                    if (i_en && !i_rempty) begin
                        state_q <= S_FETCH;
                        rr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                S_FETCH: begin
                    div_q   <= '0;
                    state_q <= S_LOAD;
                end

                // FIFO data is valid here, one clock after the request
                S_LOAD: begin
                    shift_q  <= i_rdata;
`ifdef SER_PARITY_EN
                    parity_q <= ^i_rdata;
`endif
                    sync_q   <= c_SYNC_ALIGNED << 1;
                    tx_q     <= c_SYNC_ALIGNED[15];
                    active_q <= 1'b1;
                    bit_q    <= '0;
                    div_q    <= '0;
                    state_q  <= S_SYNC;
                end

                S_SYNC: begin
                    if (div_last) begin
                        if (bit_q == c_SYNC_LAST) begin
                            bit_q   <= '0;
                            tx_q    <= shift_q[LOGIC_SIZE-1];
                            shift_q <= shift_q << 1;
                            state_q <= S_DATA;
                        end else begin
                            bit_q  <= bit_d;
                            tx_q   <= sync_q[15];
                            sync_q <= sync_q << 1;
                        end
                    end
                end

                S_DATA: begin
                    if (div_last) begin
                        if (bit_q == c_DATA_LAST) begin
                            bit_q      <= '0;
                            word_cnt_q <= word_cnt_d;
`ifdef SER_PARITY_EN
                            tx_q       <= parity_q;
                            state_q    <= S_PARITY;
`else
                            tx_q       <= 1'b1;
                            state_q    <= S_GAP;
`endif
                        end else begin
                            bit_q   <= bit_d;
                            tx_q    <= shift_q[LOGIC_SIZE-1];
                            shift_q <= shift_q << 1;
                        end
                    end
                end

`ifdef SER_PARITY_EN
                S_PARITY: begin
                    if (div_last) begin
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
`endif

                // Enable and empty are only re-examined at the very end of the gap
                S_GAP: begin
                    tx_q <= 1'b1;
                    if (div_last) begin
                        if (bit_q == c_GAP_LAST) begin
                            bit_q    <= '0;
                            active_q <= 1'b0;
                            if (i_en && !i_rempty) begin
                                state_q <= S_FETCH;
                                rr_q    <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_d;
                        end
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    tx_q     <= 1'b1;
                    active_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rr        = rr_q;
    assign o_tx        = tx_q;
    assign o_tx_active = active_q;
    assign o_busy      = busy_q;
    assign o_word_cnt  = word_cnt_q;

endmodule
`default_nettype wire
